// File: rtl/jtag_host_driver.sv
// jtag_host_driver: JTAG initiator that runs TAP-reset, IR/DR shift and run-idle commands on a TAP
// Ports:
//   clk, rst             system clock and asynchronous active-high reset
//   cmd_valid/cmd_ready  command handshake; cmd_op (0 RESET, 1 SHIFT_IR, 2 SHIFT_DR, 3 RUNTEST),
//                        cmd_len (shift bits or TCK count), cmd_data (TDI bits, LSB first)
//   rsp_valid/rsp_ready  response handshake; rsp_data (captured TDO, bit i = i-th shifted bit),
//                        rsp_err (command rejected, no TCK issued)
//   tck, tms, tdi, tdo   JTAG pins; trst is the active-high JTAG test reset
// Build option: define JTAG_HOST_TRST_EN to hold trst high for 2 TCK periods ahead of the TMS reset
// sequence of every RESET op; when undefined trst is tied to 0.
module jtag_host_driver #(
   parameter int MAX_LEN = 64,
   parameter int LEN_W   = 7,
   parameter int TCK_DIV = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic [MAX_LEN-1:0] cmd_data,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [MAX_LEN-1:0] rsp_data,
   output logic               rsp_err,
   output logic               tck,
   output logic               tms,
   output logic               tdi,
   input  logic               tdo,
   output logic               trst
);
   localparam int DW = $clog2(TCK_DIV + 1);
   localparam logic [1:0] OP_RESET = 2'd0, OP_IR = 2'd1, OP_DR = 2'd2, OP_RUN = 2'd3;
   typedef enum logic [2:0] {IDLE, PRE, SHIFT, POST, RST_SEQ, RUN, RESP, TRST_HOLD} state_t;
   state_t state, adv_state;
   logic [LEN_W-1:0] cnt, adv_cnt, len;
   logic [DW-1:0] div;
   logic [1:0] op;
   logic [MAX_LEN-1:0] data, cap;
   logic synced, phase_end, last, adv_tms, adv_tdi, bad, is_shift;
   // cnt is the TCK index inside the current state; adv_* describe the TCK period that follows it
   always_comb begin
      phase_end = div == DW'(TCK_DIV - 1);
      is_shift  = cmd_op == OP_IR || cmd_op == OP_DR;
      bad       = (cmd_op != OP_RESET && !synced) || (is_shift && (cmd_len == '0 || cmd_len > LEN_W'(MAX_LEN)));
      last      = (state == RST_SEQ) ? cnt == LEN_W'(5)
                : (state == PRE)     ? cnt == ((op == OP_IR) ? LEN_W'(3) : LEN_W'(2))
                : (state == POST)    ? cnt == LEN_W'(1)
                :                      cnt == len - 1'b1;
      adv_state = !last ? state : (state == PRE) ? SHIFT : (state == SHIFT) ? POST : RESP;
      adv_cnt   = last ? '0 : cnt + 1'b1;
      // PRE walks Select-DR(-IR) to Shift; the final shift bit and POST leave through Update to Run-Test/Idle
      adv_tms   = (adv_state == PRE)     ? ((op == OP_IR) ? adv_cnt < LEN_W'(2) : adv_cnt == '0)
                : (adv_state == SHIFT)   ? adv_cnt == len - 1'b1
                : (adv_state == POST)    ? adv_cnt == '0
                : (adv_state == RST_SEQ) ? adv_cnt < LEN_W'(5)
                :                          1'b0;
      adv_tdi   = adv_state == SHIFT && |(data & (MAX_LEN'(1) << adv_cnt));
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         div       <= '0;
         len       <= '0;
         op        <= OP_RESET;
         data      <= '0;
         cap       <= '0;
         synced    <= 1'b0;
         tck       <= 1'b0;
         tms       <= 1'b1;
         tdi       <= 1'b0;
         cmd_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
`ifdef JTAG_HOST_TRST_EN
         trst      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (cmd_valid) begin
               op        <= cmd_op;
               len       <= cmd_len;
               data      <= cmd_data;
               cap       <= '0;
               cnt       <= '0;
               div       <= '0;
               tdi       <= 1'b0;
               cmd_ready <= 1'b0;
               if (bad || (cmd_op == OP_RUN && cmd_len == '0)) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= bad;
                  rsp_data  <= '0;
               end else if (cmd_op == OP_RESET) begin
`ifdef JTAG_HOST_TRST_EN
                  state <= TRST_HOLD;
                  trst  <= 1'b1;
`else
                  state <= RST_SEQ;
                  tms   <= 1'b1;
`endif
               end else begin
                  state <= (cmd_op == OP_RUN) ? RUN : PRE;
                  tms   <= cmd_op != OP_RUN;
               end
            end
            RESP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               cmd_ready <= 1'b1;
               state     <= IDLE;
            end
`ifdef JTAG_HOST_TRST_EN
            // four tck-low phases, i.e. two TCK periods, with trst asserted
            TRST_HOLD: begin
               div <= phase_end ? '0 : div + 1'b1;
               if (phase_end) cnt <= cnt + 1'b1;
               if (phase_end && cnt == LEN_W'(3)) begin
                  trst  <= 1'b0;
                  state <= RST_SEQ;
                  cnt   <= '0;
                  tms   <= 1'b1;
               end
            end
`endif
            default: begin
               div <= phase_end ? '0 : div + 1'b1;
               if (phase_end && !tck) begin
                  tck <= 1'b1;
                  if (state == SHIFT) cap <= cap | (MAX_LEN'(tdo) << cnt);
               end else if (phase_end) begin
                  tck   <= 1'b0;
                  state <= adv_state;
                  cnt   <= adv_cnt;
                  tms   <= adv_tms;
                  tdi   <= adv_tdi;
                  if (adv_state == RESP) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b0;
                     rsp_data  <= cap;
                     if (state == RST_SEQ) synced <= 1'b1;
                  end
               end
            end
         endcase
      end
   end
`ifdef JTAG_HOST_TRST_EN
   // trst is a sequencer register driven above
`else
   assign trst = 1'b0;
`endif
endmodule

// File: tb/tb_jtag_host_driver.sv
// tb_jtag_host_driver: randomized check of jtag_host_driver against a TAP model and a command-level reference
module tb_jtag_host_driver;
   localparam int MAX_LEN = 64, LEN_W = 7, TCK_DIV = 2;
   localparam int TAP_RTI = 1, CAP_DR = 3, SH_DR = 4, CAP_IR = 10, SH_IR = 11;
   logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, rsp_ready = 1'b0, tdo = 1'b0;
   logic [1:0] cmd_op = 2'd0;
   logic [LEN_W-1:0] cmd_len = '0;
   logic [MAX_LEN-1:0] cmd_data = '0;
   logic cmd_ready, rsp_valid, rsp_err, tck, tms, tdi, trst;
   logic [MAX_LEN-1:0] rsp_data;
   int checks = 0, errors = 0;
   bit tms_q[$], tdi_q[$];
   int tap = 0;
   logic byp = 1'b0, cap_bit = 1'b0;
   logic [63:0] ir_sr = '0, ir_cap = '0;
   bit synced_m = 1'b0;

   always #5 clk = ~clk;

   jtag_host_driver #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .TCK_DIV(TCK_DIV)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .trst(trst)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] pack(input bit q[$]);
      logic [127:0] v;
      v = '0;
      foreach (q[k]) v[k] = q[k];
      return v;
   endfunction

   // IEEE 1149.1 TAP controller
   function automatic int tap_next(input int s, input bit m);
      case (s)
         0:      return m ? 0 : 1;
         1:      return m ? 2 : 1;
         2:      return m ? 9 : 3;
         3, 4:   return m ? 5 : 4;
         5:      return m ? 8 : 6;
         6:      return m ? 7 : 6;
         7:      return m ? 8 : 4;
         8, 15:  return m ? 2 : 1;
         9:      return m ? 0 : 10;
         10, 11: return m ? 12 : 11;
         12:     return m ? 15 : 13;
         13:     return m ? 14 : 13;
         14:     return m ? 15 : 11;
         default: return 0;
      endcase
   endfunction

   // target model: 1-bit bypass DR looping tdi back, long IR capturing ir_cap; tdo changes after each rising tck
   initial forever begin
      @(posedge tck);
      tms_q.push_back(tms);
      tdi_q.push_back(tdi);
      if (tap == CAP_DR) byp = cap_bit;
      else if (tap == SH_DR) byp = tdi;
      else if (tap == CAP_IR) ir_sr = ir_cap;
      else if (tap == SH_IR) ir_sr = {tdi, ir_sr[63:1]};
      tap = tap_next(tap, tms);
      tdo = (tap == SH_IR) ? ir_sr[0] : byp;
   end

   task automatic run_cmd(input logic [1:0] op, input int len, input logic [63:0] d, input int hold);
      bit exp_tms[$], exp_tdi[$], pre[$], err;
      logic [127:0] mask;
      logic [63:0] exp_data, held;
      int n, trst_n, trst_exp, moved;
      err = (op != 2'd0 && !synced_m) || ((op == 2'd1 || op == 2'd2) && (len == 0 || len > MAX_LEN));
      mask = (128'd1 << len) - 128'd1;
      exp_data = '0;
      trst_exp = 0;
      if (!err) begin
         if (op == 2'd0) pre = '{1, 1, 1, 1, 1, 0};
         else if (op == 2'd1) pre = '{1, 1, 0, 0};
         else if (op == 2'd2) pre = '{1, 0, 0};
         foreach (pre[k]) begin exp_tms.push_back(pre[k]); exp_tdi.push_back(1'b0); end
         if (op == 2'd1 || op == 2'd2) begin
            for (int i = 0; i < len; i++) begin exp_tms.push_back(i == len - 1); exp_tdi.push_back(d[i]); end
            exp_tms.push_back(1'b1); exp_tdi.push_back(1'b0);
            exp_tms.push_back(1'b0); exp_tdi.push_back(1'b0);
         end
         if (op == 2'd3) for (int i = 0; i < len; i++) begin exp_tms.push_back(1'b0); exp_tdi.push_back(1'b0); end
         if (op == 2'd1) exp_data = ir_cap & mask[63:0];
         if (op == 2'd2) exp_data = ((d << 1) | 64'(cap_bit)) & mask[63:0];
`ifdef JTAG_HOST_TRST_EN
         if (op == 2'd0) trst_exp = 4 * TCK_DIV;
`endif
      end
      tms_q.delete();
      tdi_q.delete();
      check("idle_tck", tck, 0);
      check("cmd_ready", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_op = op; cmd_len = LEN_W'(len); cmd_data = d;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      n = 0;
      trst_n = trst;
      while (!rsp_valid && n < 1000) begin @(posedge clk); #1; n++; trst_n += trst; end
      check("rsp_valid", rsp_valid, 1);
      check("latency", n, exp_tms.size() * 2 * TCK_DIV + trst_exp);
      check("trst_clks", trst_n, trst_exp);
      check("rsp_err", rsp_err, err);
      check("rsp_data", rsp_data, exp_data);
      check("tck_edges", tms_q.size(), exp_tms.size());
      check("tms_seq", pack(tms_q), pack(exp_tms));
      check("tdi_seq", pack(tdi_q), pack(exp_tdi));
      if (!err) check("tap_in_rti", tap, TAP_RTI);
      held = rsp_data;
      moved = 0;
      repeat (hold) begin
         @(posedge clk); #1;
         if (!rsp_valid || rsp_data !== held || cmd_ready || tck) moved++;
      end
      if (hold > 0) check("hold_stable", moved, 0);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("rsp_drop", rsp_valid, 0);
      check("ready_back", cmd_ready, 1);
      if (!err && op == 2'd0) synced_m = 1'b1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_tck", tck, 0);
      check("rst_tms", tms, 1);
      check("rst_tdi", tdi, 0);
      check("rst_trst", trst, 0);
      check("rst_ready", cmd_ready, 1);
      check("rst_valid", rsp_valid, 0);
      check("rst_data", rsp_data, 0);
      check("rst_err", rsp_err, 0);
      run_cmd(2'd2, 8, 64'hA5, 0);
      run_cmd(2'd0, 0, 64'h0, 0);
      ir_cap = 64'h1;
      run_cmd(2'd1, 4, 64'h2, 0);
      cap_bit = 1'b1;
      run_cmd(2'd2, 64, 64'hDEADBEEF_01234567, 0);
      run_cmd(2'd2, 65, 64'hFFFF, 0);
      run_cmd(2'd1, 0, 64'hFFFF, 0);
      run_cmd(2'd3, 0, 64'h0, 0);
      cap_bit = 1'b0;
      run_cmd(2'd2, 16, {$urandom, $urandom}, 10);
      run_cmd(2'd3, 5, 64'h0, 0);
      for (int r = 0; r < 25; r++) begin
         ir_cap = {$urandom, $urandom};
         cap_bit = 1'($urandom_range(0, 1));
         run_cmd(2'($urandom_range(0, 3)), $urandom_range(0, 70), {$urandom, $urandom}, $urandom_range(0, 2));
      end
      cmd_valid = 1'b1; cmd_op = 2'd2; cmd_len = LEN_W'(64); cmd_data = {$urandom, $urandom};
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (42) @(posedge clk);
      #2;
      check("pre_abort_tck", tck, 1);
      rst = 1'b1;
      #1;
      synced_m = 1'b0;
      check("abort_tck", tck, 0);
      check("abort_tms", tms, 1);
      check("abort_ready", cmd_ready, 1);
      check("abort_valid", rsp_valid, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      run_cmd(2'd2, 8, 64'h3C, 0);
      run_cmd(2'd3, 4, 64'h0, 0);
      run_cmd(2'd0, 0, 64'h0, 0);
      ir_cap = {$urandom, $urandom};
      run_cmd(2'd1, 5, 64'h15, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/jtag_host_driver.md
Name: jtag_host_driver

Overview:
- JTAG initiator: the host-side master that drives tck/tms/tdi and samples tdo of a JTAG TAP, such as the debug access port's TAP and debug port.
- Accepts IR-shift, DR-shift, TAP-reset and run-idle commands over a valid/ready interface.
- Generates the TMS navigation sequences and returns the captured TDO bits as a response.
- Used in on-chip self-test and FPGA bring-up benches.

Parameters:
- MAX_LEN, 64, maximum shift length in bits.
- LEN_W, 7, width of cmd_len; must satisfy 2^LEN_W > MAX_LEN.
- TCK_DIV, 2, clk cycles per TCK half-period; ≥1.

Ports:
- clk  in  1  system clock; sole clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_op  in  2  0=RESET, 1=SHIFT_IR, 2=SHIFT_DR, 3=RUNTEST.
- cmd_len  in  LEN_W  shift bit count, or TCK count for RUNTEST.
- cmd_data  in  MAX_LEN  TDI bits, LSB shifted first.
- rsp_valid  out  1  response valid; held until rsp_ready.
- rsp_ready  in  1  response consumed.
- rsp_data  out  MAX_LEN  captured TDO; bit i = i-th shifted bit; bits ≥ len are 0.
- rsp_err  out  1  command rejected, no TCK issued.
- tck  out  1  JTAG test clock.
- tms  out  1  JTAG mode select.
- tdi  out  1  JTAG data to target.
- tdo  in  1  JTAG data from target.
- trst  out  1  JTAG test reset, active-high.

Behaviour:
- Reset values: tck=0, tms=1, tdi=0, trst=0, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, synced=0. All state is cleared asynchronously.
- Reset mid-operation: the command is abandoned with no response, and synced=0.
- TCK period timing:
  - One TCK period = 2*TCK_DIV clk cycles: low phase first, then high phase.
  - tms/tdi update on the clk edge that drives tck 1→0, or at the start of the first low phase.
  - tdo is sampled on the clk edge that drives tck 0→1.
  - tck stays 0 when idle.
- FSM states: IDLE → (PRE → SHIFT → POST | RST_SEQ | RUN) → RESP → IDLE.
- cmd_ready=1 only in IDLE. The command is latched on acceptance.
- RESET: 5 TCK with tms=1, then 1 TCK with tms=0, so the TAP ends in Run-Test/Idle. Sets synced=1.
- SHIFT_IR:
  - PRE tms 1,1,0,0.
  - SHIFT: cmd_len TCK with tdi=cmd_data[i]; tms=0, except tms=1 on the last bit.
  - POST tms 1,0.
  - Total 6+len TCK.
- SHIFT_DR: PRE tms 1,0,0; otherwise the same as SHIFT_IR. Total 5+len TCK.
- RUNTEST: cmd_len TCK with tms=0. Length 0 gives an immediate response with rsp_err=0.
- tdi=0 outside SHIFT.
- Error cases, all with zero TCK and rsp_err=1:
  - SHIFT with cmd_len=0.
  - SHIFT with cmd_len>MAX_LEN.
  - SHIFT_IR, SHIFT_DR or RUNTEST while synced=0.
- RESP: rsp_valid=1 the cycle after the final low→high phase completes. It holds rsp_data/rsp_err stable until rsp_valid&rsp_ready, then returns to IDLE with cmd_ready=1 the next cycle.
- Back-to-back commands always start and end in Run-Test/Idle. No TCK is issued between commands.

Optional Feature:
- Macro: JTAG_HOST_TRST_EN.
- Defined: a RESET op first drives trst=1 for 2 TCK periods (tck held low), deasserts it, then runs the 6-TCK TMS sequence.
- Undefined: trst is constant 0 and RESET uses the TMS sequence only.

Test Plan:
- After rst, SHIFT_DR len=8 → zero TCK edges, rsp_valid with rsp_err=1, rsp_data=0.
- RESET with TCK_DIV=2 → 6 tck rising edges in 24 clk; tms sequence 1,1,1,1,1,0; synced set; rsp_err=0. With JTAG_HOST_TRST_EN: trst high for 8 clk first.
- SHIFT_IR len=4 data=0x2, tdo model returns 0x1 (LSB first) → tms 1,1,0,0,0,0,0,1,1,0; tdi in shift bits 0,1,0,0; rsp_data=0x1.
- SHIFT_DR len=64 data=0xDEADBEEF_01234567 against a loopback bypass-style TAP model → 69 TCK; rsp_data equals data delayed by one bit; the first captured bit equals the model's capture value.
- SHIFT_DR len=65 (MAX_LEN=64) → rsp_err=1, no TCK. RUNTEST len=0 → immediate response, rsp_err=0.
- Hold rsp_ready=0 for 10 cycles after a SHIFT_DR → rsp_valid/rsp_data stable, cmd_ready=0. Assert rst mid-SHIFT → tck=0, tms=1, cmd_ready=1 in the same cycle, and the next SHIFT returns an error until a RESET is issued.
